pipe_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 39 +++
 rtl/pipe_shifter_shift_stage.sv | 89 ++++++++
 rtl/pipe_shifter.sv | 104 ++++++++++
 tb/tb_pipe_shifter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared types and helpers for the pipelined barrel shifter (pipe_shifter).
//   shift_op_e   : operation encoding carried down the pipe with each operand.
//   bit_reverse  : reverses the low 'w' bits of a vector (w <= MAX_WIDTH).
//   first_layer  : index of the first shift layer placed in a given stage.
// -----------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } shift_op_e;

    // Widest datapath the shifter supports; bit_reverse works on this size.
    localparam int MAX_WIDTH = 128;

    // Reverse the low w bits of d; bits at and above w come back as zero.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(
        input logic [MAX_WIDTH-1:0] d,
        input int                   w
    );
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = d[w-1-i];
        end
        return r;
    endfunction

    // Layer j lives in stage floor(j*stages/shw), so the first layer of a
    // stage is ceil(stage*shw/stages).
    function automatic int first_layer(input int stage, input int shw, input int stages);
        return (stage * shw + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/pipe_shifter_shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One pipeline stage of pipe_shifter: NUM_LAYERS combinational right-shift
// layers (layer FIRST_LAYER+i shifts by 2**(FIRST_LAYER+i) when that shamt bit
// is set) followed by the stage register and its ready-chain term.
// Build macro: PIPE_SHIFTER_ROT_EN adds a wrap path to each layer for ROR.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   prev_*         operation arriving from the previous stage (or entry)
//   ready          this stage can accept prev_* this cycle
//   next_ready     the following stage (or downstream) can accept
//   valid/data/... registered contents of this stage
// -----------------------------------------------------------------------------
module shift_stage
    import shifter_pkg::*;
#(
    parameter int  WIDTH       = 32,
    parameter int  FIRST_LAYER = 0,
    parameter int  NUM_LAYERS  = 1,
    localparam int SHW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    output logic             ready,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_shamt,
    input  shift_op_e        prev_op,
    input  logic             prev_fill,
    input  logic             next_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   shamt,
    output shift_op_e        op,
    output logic             fill
);

    logic             wrap;
    logic [WIDTH-1:0] shifted;

`ifdef PIPE_SHIFTER_ROT_EN
    // Rotate: bits leaving the LSB re-enter at the MSB.
    assign wrap = (prev_op == ROR);
`else
    assign wrap = 1'b0;
`endif

    // NOTE: blocking assignments in always_comb build a chain of layers; each
    // iteration sees the previous layer's result, and the default first line
    // keeps the block latch-free.
    always_comb begin
        shifted = prev_data;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (prev_shamt[FIRST_LAYER + i]) begin
                if (wrap) begin
                    shifted = (shifted >> (1 << (FIRST_LAYER + i)))
                            | (shifted << (WIDTH - (1 << (FIRST_LAYER + i))));
                end else begin
                    shifted = (shifted >> (1 << (FIRST_LAYER + i)))
                            | ({WIDTH{prev_fill}} & ~({WIDTH{1'b1}} >> (1 << (FIRST_LAYER + i))));
                end
            end
        end
    end

    // A stage may take new data whenever it is empty or its content leaves.
    assign ready = !valid || next_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset as well, so out_data
            // reads zero (and out_zero one) right after reset.
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
            op    <= SLL;
            fill  <= 1'b0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data  <= shifted;
                shamt <= prev_shamt;
                op    <= prev_op;
                fill  <= prev_fill;
            end
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// -----------------------------------------------------------------------------
// pipe_shifter
// Parametrised, pipelined barrel shifter with valid/ready on both sides.
// All shifting is done by a right-shift core: left shifts are bit-reversed at
// entry and reversed back at the output, steered by the op that travels with
// the data. Shift amount is always taken modulo WIDTH.
// Build macro: PIPE_SHIFTER_ROT_EN -- when defined op 11 is ROR, otherwise
// op 11 behaves as SRL and no wrap logic exists.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data/in_shamt      operand and shift amount
//   in_op                 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid/out_ready   output handshake
//   out_data/out_zero     result and result==0 flag
// -----------------------------------------------------------------------------
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  STAGES = 2,
    localparam int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    // Index b is the boundary feeding stage b; index STAGES is the output.
    logic             valid_s [STAGES+1];
    logic             ready_s [STAGES+1];
    logic [WIDTH-1:0] data_s  [STAGES+1];
    logic [SHW-1:0]   shamt_s [STAGES+1];
    shift_op_e        op_s    [STAGES+1];
    logic             fill_s  [STAGES+1];

    shift_op_e        entry_op;
    logic [WIDTH-1:0] in_rev;
    logic [WIDTH-1:0] out_rev;
    logic             unused_tail;

`ifdef PIPE_SHIFTER_ROT_EN
    assign entry_op = shift_op_e'(in_op);
`else
    assign entry_op = (in_op == 2'b11) ? SRL : shift_op_e'(in_op);
`endif

    assign in_rev = WIDTH'(bit_reverse(MAX_WIDTH'(in_data), WIDTH));

    // Entry: left shifts enter reversed; fill bit is fixed here for the whole trip.
    assign valid_s[0] = in_valid;
    assign data_s[0]  = (entry_op == SLL) ? in_rev : in_data;
    assign shamt_s[0] = in_shamt;
    assign op_s[0]    = entry_op;
    assign fill_s[0]  = (entry_op == SRA) && in_data[WIDTH-1];

    assign ready_s[STAGES] = out_ready;
    assign in_ready        = ready_s[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FL = first_layer(s, SHW, STAGES);
        localparam int NL = first_layer(s + 1, SHW, STAGES) - FL;

        shift_stage #(
            .WIDTH       (WIDTH),
            .FIRST_LAYER (FL),
            .NUM_LAYERS  (NL)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (valid_s[s]),
            .ready      (ready_s[s]),
            .prev_data  (data_s[s]),
            .prev_shamt (shamt_s[s]),
            .prev_op    (op_s[s]),
            .prev_fill  (fill_s[s]),
            .next_ready (ready_s[s+1]),
            .valid      (valid_s[s+1]),
            .data       (data_s[s+1]),
            .shamt      (shamt_s[s+1]),
            .op         (op_s[s+1]),
            .fill       (fill_s[s+1])
        );
    end

    // Output: undo the entry reversal for left shifts (pure wiring).
    assign out_rev   = WIDTH'(bit_reverse(MAX_WIDTH'(data_s[STAGES]), WIDTH));
    assign out_valid = valid_s[STAGES];
    assign out_data  = (op_s[STAGES] == SLL) ? out_rev : data_s[STAGES];
    // Reversal does not change zero-ness, so test the register directly.
    assign out_zero  = (data_s[STAGES] == '0);

    // Shift amount and fill are fully consumed by the last stage.
    assign unused_tail = ^{shamt_s[STAGES], fill_s[STAGES]};

endmodule

// File: tb/tb_pipe_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipe_shifter
// Directed vectors, backpressure and reset sequences on a WIDTH=32/STAGES=2
// instance, plus randomized traffic on STAGES=1,2,5 instances checked against
// an arithmetic reference model. Honours PIPE_SHIFTER_ROT_EN.
// -----------------------------------------------------------------------------
module tb_pipe_shifter;

`ifdef PIPE_SHIFTER_ROT_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    localparam int NOPS      = 1000;
    localparam int STRICT_END = 600;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: the shift written directly as arithmetic.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int s);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: begin
                if (ROT) return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
                else     return d >> s;
            end
        endcase
    endfunction

    // ---------------------------------------------------------------- directed DUT
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;

    pipe_shifter #(.WIDTH(32), .STAGES(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    // One operation with out_ready=1: result must appear exactly 2 cycles later.
    task automatic run_one(input vec_t v);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = v.op;
        in_data   = v.d;
        in_shamt  = v.sh;
        #1 check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({v.name, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({v.name, "_valid"}, 32'(out_valid), 32'd1);
        check({v.name, "_data"}, out_data, v.exp);
        check({v.name, "_zero"}, 32'(out_zero), 32'(v.exp == 32'd0));
    endtask

    initial begin : main
        int          accepted, next, idx, emitted;
        logic [31:0] bp_exp [6];

        vecs[0]  = '{"sll1_31",   2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1]  = '{"sra_neg4",  2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[2]  = '{"srl_4",     2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[3]  = '{"sll_0",     2'b00, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[4]  = '{"srl_0",     2'b01, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[5]  = '{"sra_0",     2'b10, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[6]  = '{"ror_0",     2'b11, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
        vecs[7]  = '{"ror_1",     2'b11, 32'h0000_0001, 5'd1,  ROT ? 32'h8000_0000 : 32'h0000_0000};
        vecs[8]  = '{"sra_pos31", 2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        vecs[9]  = '{"sra_neg31", 2'b10, 32'hFFFF_FFF0, 5'd31, 32'hFFFF_FFFF};
        vecs[10] = '{"sll_4",     2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780};
        vecs[11] = '{"srl_8",     2'b01, 32'h1234_5678, 5'd8,  32'h0012_3456};
        vecs[12] = '{"ror_8",     2'b11, 32'h1234_5678, 5'd8,  ROT ? 32'h7812_3456 : 32'h0012_3456};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_shamt = '0; in_op = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_data",  out_data,        32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd1);

        for (int i = 0; i < 13; i++) run_one(vecs[i]);

        // Backpressure: out_ready low for 5 cycles while offering 1..6 (SLL by 1).
        @(negedge clk);
        accepted = 0;
        next     = 1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_op     = 2'b00;
            in_shamt  = 5'd1;
            in_data   = 32'(next);
            #1;
            if (in_ready) begin
                accepted++;
                next++;
            end
        end
        @(negedge clk);
        #1;
        check("bp_accepted",  32'(accepted),  32'd2);
        check("bp_in_ready",  32'(in_ready),  32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", out_data,        32'd2);

        for (int i = 0; i < 6; i++) bp_exp[i] = 32'(2 * (i + 1));
        idx = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (next <= 6);
            in_data   = 32'(next);
            #1;
            if (out_valid) begin
                check($sformatf("bp_out%0d", idx), out_data, bp_exp[idx]);
                idx++;
            end
            if (in_valid && in_ready) next++;
        end
        check("bp_all_out", 32'(idx), 32'd6);
        @(negedge clk);
        in_valid = 1'b0;

        // Reset with two operations in flight: neither may ever come out.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_shamt = 5'd3; in_data = 32'h0000_0011;
        @(negedge clk);
        in_data = 32'h0000_0022;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data",  out_data,        32'd0);
        check("mid_rst_out_zero",  32'(out_zero),  32'd1);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        emitted = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) emitted++;
        end
        check("mid_rst_no_emit", 32'(emitted), 32'd0);

        // Wait for the random sweeps, with a bound.
        for (int c = 0; c < 30000; c++) begin
            if (g_rand[0].done && g_rand[1].done && g_rand[2].done) break;
            @(negedge clk);
        end
        check("rand_done", 32'(g_rand[0].done && g_rand[1].done && g_rand[2].done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------------------------------------------------------- random sweeps
    for (genvar k = 0; k < 3; k++) begin : g_rand
        localparam int ST = (k == 0) ? 1 : ((k == 1) ? 2 : 5);

        logic        r_rst_n, r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_out_zero;
        logic [31:0] r_in_data, r_out_data;
        logic [4:0]  r_in_shamt;
        logic [1:0]  r_in_op;
        bit          done = 1'b0;

        pipe_shifter #(.WIDTH(32), .STAGES(ST)) u_dut (
            .clk       (clk),
            .rst_n     (r_rst_n),
            .in_valid  (r_in_valid),
            .in_ready  (r_in_ready),
            .in_data   (r_in_data),
            .in_shamt  (r_in_shamt),
            .in_op     (r_in_op),
            .out_valid (r_out_valid),
            .out_ready (r_out_ready),
            .out_data  (r_out_data),
            .out_zero  (r_out_zero)
        );

        initial begin : stim
            logic [31:0] exp_q [$];
            int          cyc_q [$];
            int          cyc, sent, recv, lat, c0;
            logic [31:0] exp;
            logic        ghost;

            r_rst_n = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0;
            r_in_data = '0; r_in_shamt = '0; r_in_op = '0;
            repeat (3) @(negedge clk);
            r_rst_n = 1'b1;
            cyc = 0; sent = 0; recv = 0;

            while (recv < NOPS && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                // No backpressure early on, so latency must be exact there.
                r_out_ready = (cyc < STRICT_END) ? 1'b1 : ($urandom_range(0, 3) != 0);
                r_in_valid  = (sent < NOPS) && ($urandom_range(0, 4) != 0);
                r_in_op     = 2'($urandom_range(0, 3));
                r_in_shamt  = 5'($urandom_range(0, 31));
                case ($urandom_range(0, 3))
                    0:       r_in_data = 32'h8000_0000 | $urandom;
                    1:       r_in_data = 32'h0000_0001 << $urandom_range(0, 31);
                    default: r_in_data = $urandom;
                endcase
                #1;
                if (r_out_valid && r_out_ready) begin
                    ghost = (exp_q.size() == 0);
                    check($sformatf("st%0d_no_ghost", ST), 32'(ghost), 32'd0);
                    if (!ghost) begin
                        exp = exp_q.pop_front();
                        c0  = cyc_q.pop_front();
                        lat = cyc - c0;
                        check($sformatf("st%0d_data_%0d", ST, recv), r_out_data, exp);
                        check($sformatf("st%0d_zero_%0d", ST, recv), 32'(r_out_zero), 32'(exp == 32'd0));
                        if (c0 + ST < STRICT_END)
                            check($sformatf("st%0d_lat_%0d", ST, recv), 32'(lat), 32'(ST));
                        else
                            check($sformatf("st%0d_latmin_%0d", ST, recv), 32'(lat >= ST), 32'd1);
                    end
                    recv++;
                end
                if (r_in_valid && r_in_ready) begin
                    exp_q.push_back(ref_shift(r_in_op, r_in_data, int'(r_in_shamt)));
                    cyc_q.push_back(cyc);
                    sent++;
                end
            end
            r_in_valid = 1'b0;
            check($sformatf("st%0d_all_received", ST), 32'(recv), 32'(NOPS));
            done = 1'b1;
        end
    end

endmodule
